// File: rtl/tx_ts_queue_ctrl_pkg.sv
// Shared PTPv2 definitions for the TX timestamp queue: message types,
// tsu_cfg bit positions, FSM states and the queued entry layout.
package tx_ts_queue_ctrl_pkg;

  localparam logic [3:0] MSG_SYNC        = 4'd0;
  localparam logic [3:0] MSG_DELAY_REQ   = 4'd1;
  localparam logic [3:0] MSG_PDELAY_REQ  = 4'd2;
  localparam logic [3:0] MSG_PDELAY_RESP = 4'd3;

  localparam int unsigned CFG_ONE_STEP      = 0;
  localparam int unsigned CFG_TS_IRQ_EN     = 8;
  localparam int unsigned CFG_TS_CAPTURE_EN = 9;

  localparam int unsigned ENTRY_W = 100;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_CLS = 2'd1,
    ST_PUSH     = 2'd2
  } state_t;

  typedef struct packed {
    logic [47:0] sec;
    logic [31:0] ns;
    logic [15:0] seqid;
    logic [3:0]  msgtype;
  } ts_entry_t;

  // In one-step mode Sync/Pdelay_Resp are stamped on the wire, so only the
  // request messages still need a software-visible egress timestamp.
  function automatic logic is_qualified(input logic [3:0] msgtype, input logic one_step);
    logic q;
    q = 1'b0;
    if (!msgtype[3]) begin
      if (one_step)
        q = (msgtype == MSG_DELAY_REQ) || (msgtype == MSG_PDELAY_REQ);
      else
        q = (msgtype == MSG_SYNC) || (msgtype == MSG_DELAY_REQ) ||
            (msgtype == MSG_PDELAY_REQ) || (msgtype == MSG_PDELAY_RESP);
    end
    return q;
  endfunction

endpackage

// File: rtl/tx_ts_fifo.sv
// First-word-fall-through timestamp FIFO with sticky head when empty.
// Full-push policy selected by TX_TS_DROP_OLDEST_EN (overwrite oldest vs drop newest).
module tx_ts_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2,
  parameter int unsigned DW    = 100
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata,
  output logic [AW:0]   o_count,
  output logic          o_valid,
  output logic          o_drop
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_hold;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_wr;
  logic w_rd;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_pop   = i_pop & ~w_empty;

`ifdef TX_TS_DROP_OLDEST_EN
  logic w_ovw;
  assign w_ovw  = i_push & w_full & ~w_pop;
  assign w_wr   = i_push;
  assign w_rd   = w_pop | w_ovw;
  assign o_drop = w_ovw;
`else
  assign w_wr   = i_push & (~w_full | w_pop);
  assign w_rd   = w_pop;
  assign o_drop = i_push & w_full & ~w_pop;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_hold  <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_rd) r_rptr <= r_rptr + AW'(1);
      if (w_wr && !w_rd)      r_count <= r_count + (AW+1)'(1);
      else if (w_rd && !w_wr) r_count <= r_count - (AW+1)'(1);
      // Track the visible head so it stays on the outputs after the last pop.
      if (!w_empty) r_hold <= r_mem[r_rptr];
    end
  end

  assign o_rdata = w_empty ? r_hold : r_mem[r_rptr];
  assign o_count = r_count;
  assign o_valid = ~w_empty;

endmodule

// File: rtl/tx_ts_queue_ctrl.sv
// Egress timestamp capture for two-step / Delay_Req PTP event frames:
// SFD latch, parser classification, FIFO push, sticky overflow and IRQ.
// Full-FIFO behaviour selectable with TX_TS_DROP_OLDEST_EN (in tx_ts_fifo).
module tx_ts_queue_ctrl
  import tx_ts_queue_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          tx_clk,
  input  logic          tx_rst,
  input  logic          tx_clk_en_i,
  input  logic          sfd_pulse_i,
  input  logic [47:0]   tx_ts_sec_i,
  input  logic [31:0]   tx_ts_ns_i,
  input  logic          is_ptp_message_i,
  input  logic [3:0]    ptp_messageType_i,
  input  logic [15:0]   ptp_sequenceId_i,
  input  logic          frame_end_i,
  input  logic [31:0]   tsu_cfg_i,
  input  logic          ts_pop_i,
  input  logic          ts_clr_ovf_i,
  output logic          ts_valid_o,
  output logic [47:0]   ts_sec_o,
  output logic [31:0]   ts_ns_o,
  output logic [15:0]   ts_seqid_o,
  output logic [3:0]    ts_msgtype_o,
  output logic [AW:0]   ts_count_o,
  output logic          ts_overflow_o,
  output logic          ts_irq_o
);

  state_t r_state;
  state_t w_state_nxt;

  logic        w_sfd_latch;
  logic        w_cls_latch;
  logic        w_push;
  logic        w_drop;
  logic        w_valid;
  logic        w_capture_en;
  logic        w_one_step;
  logic        w_irq_en;
  logic        w_unused_cfg;

  logic [47:0] r_sec;
  logic [31:0] r_ns;
  logic [15:0] r_seqid;
  logic [3:0]  r_msgtype;

  ts_entry_t   w_wentry;
  ts_entry_t   w_head;

  assign w_one_step   = tsu_cfg_i[CFG_ONE_STEP];
  assign w_irq_en     = tsu_cfg_i[CFG_TS_IRQ_EN];
  assign w_capture_en = tsu_cfg_i[CFG_TS_CAPTURE_EN];
  assign w_unused_cfg = ^{tsu_cfg_i[31:10], tsu_cfg_i[7:1]};

  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst)           r_state <= ST_IDLE;
    else if (tx_clk_en_i) r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sfd_latch = 1'b0;
    w_cls_latch = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (sfd_pulse_i && w_capture_en) begin
          w_sfd_latch = 1'b1;
          w_state_nxt = ST_WAIT_CLS;
        end
      end
      ST_WAIT_CLS: begin
        if (is_ptp_message_i) begin
          if (is_qualified(ptp_messageType_i, w_one_step)) begin
            w_cls_latch = 1'b1;
            w_state_nxt = ST_PUSH;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (frame_end_i) begin
          w_state_nxt = ST_IDLE;
        end else if (sfd_pulse_i && w_capture_en) begin
          w_sfd_latch = 1'b1;
        end
      end
      ST_PUSH:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      r_sec     <= '0;
      r_ns      <= '0;
      r_seqid   <= '0;
      r_msgtype <= '0;
    end else if (tx_clk_en_i) begin
      if (w_sfd_latch) begin
        r_sec <= tx_ts_sec_i;
        r_ns  <= tx_ts_ns_i;
      end
      if (w_cls_latch) begin
        r_seqid   <= ptp_sequenceId_i;
        r_msgtype <= ptp_messageType_i;
      end
    end
  end

  assign w_push   = tx_clk_en_i & (r_state == ST_PUSH);
  assign w_wentry = {r_sec, r_ns, r_seqid, r_msgtype};

  tx_ts_fifo #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .DW   (ENTRY_W)
  ) u_fifo (
    .clk     (tx_clk),
    .rst     (tx_rst),
    .i_push  (w_push),
    .i_pop   (ts_pop_i),
    .i_wdata (w_wentry),
    .o_rdata (w_head),
    .o_count (ts_count_o),
    .o_valid (w_valid),
    .o_drop  (w_drop)
  );

  // A drop and a CPU clear in the same cycle leave the flag set.
  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      ts_overflow_o <= 1'b0;
      ts_irq_o      <= 1'b0;
    end else begin
      if (w_drop)            ts_overflow_o <= 1'b1;
      else if (ts_clr_ovf_i) ts_overflow_o <= 1'b0;
      ts_irq_o <= w_irq_en & w_valid;
    end
  end

  assign ts_valid_o   = w_valid;
  assign ts_sec_o     = w_head.sec;
  assign ts_ns_o      = w_head.ns;
  assign ts_seqid_o   = w_head.seqid;
  assign ts_msgtype_o = w_head.msgtype;

endmodule

// File: tb/tb_tx_ts_queue_ctrl.sv
// Directed bench for tx_ts_queue_ctrl with a queue-based reference model
// checked every cycle, plus hand-computed literal checkpoints.
module tb_tx_ts_queue_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  logic        tx_clk = 1'b0;
  logic        tx_rst = 1'b0;
  logic        tx_clk_en_i = 1'b1;
  logic        sfd_pulse_i = 1'b0;
  logic [47:0] tx_ts_sec_i = '0;
  logic [31:0] tx_ts_ns_i = '0;
  logic        is_ptp_message_i = 1'b0;
  logic [3:0]  ptp_messageType_i = '0;
  logic [15:0] ptp_sequenceId_i = '0;
  logic        frame_end_i = 1'b0;
  logic [31:0] tsu_cfg_i = '0;
  logic        ts_pop_i = 1'b0;
  logic        ts_clr_ovf_i = 1'b0;
  logic        ts_valid_o;
  logic [47:0] ts_sec_o;
  logic [31:0] ts_ns_o;
  logic [15:0] ts_seqid_o;
  logic [3:0]  ts_msgtype_o;
  logic [AW:0] ts_count_o;
  logic        ts_overflow_o;
  logic        ts_irq_o;

  tx_ts_queue_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .tx_clk(tx_clk), .tx_rst(tx_rst), .tx_clk_en_i(tx_clk_en_i),
    .sfd_pulse_i(sfd_pulse_i), .tx_ts_sec_i(tx_ts_sec_i), .tx_ts_ns_i(tx_ts_ns_i),
    .is_ptp_message_i(is_ptp_message_i), .ptp_messageType_i(ptp_messageType_i),
    .ptp_sequenceId_i(ptp_sequenceId_i), .frame_end_i(frame_end_i),
    .tsu_cfg_i(tsu_cfg_i), .ts_pop_i(ts_pop_i), .ts_clr_ovf_i(ts_clr_ovf_i),
    .ts_valid_o(ts_valid_o), .ts_sec_o(ts_sec_o), .ts_ns_o(ts_ns_o),
    .ts_seqid_o(ts_seqid_o), .ts_msgtype_o(ts_msgtype_o), .ts_count_o(ts_count_o),
    .ts_overflow_o(ts_overflow_o), .ts_irq_o(ts_irq_o)
  );

  always #5 tx_clk = ~tx_clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [47:0] sec;
    logic [31:0] ns;
    logic [15:0] seq;
    logic [3:0]  typ;
  } ent_t;

  ent_t        q[$];
  ent_t        m_last = '{0, 0, 0, 0};
  ent_t        m_pent = '{0, 0, 0, 0};
  bit          m_open = 0;
  bit          m_pend = 0;
  logic [47:0] m_sec = '0;
  logic [31:0] m_ns = '0;
  bit          m_ovf = 0;
  bit          m_irq = 0;

  function automatic bit qual(input logic [3:0] t, input bit one_step);
    if (one_step) return (t == 4'd1) || (t == 4'd2);
    return t < 4'd4;
  endfunction

  always @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      q.delete();
      m_last = '{0, 0, 0, 0};
      m_open = 0; m_pend = 0; m_sec = '0; m_ns = '0; m_ovf = 0; m_irq = 0;
    end else begin
      bit pop_ok, do_push, full_before, drop, was_nonempty;
      ent_t pe;
      pop_ok = ts_pop_i && (q.size() != 0);
      full_before = (q.size() == DEPTH);
      was_nonempty = (q.size() != 0);
      do_push = 0; drop = 0;
      pe = '{0, 0, 0, 0};
      if (tx_clk_en_i) begin
        if (m_pend) begin
          do_push = 1; pe = m_pent; m_pend = 0;
        end else if (m_open) begin
          if (is_ptp_message_i) begin
            m_open = 0;
            if (qual(ptp_messageType_i, tsu_cfg_i[0])) begin
              m_pend = 1;
              m_pent = '{m_sec, m_ns, ptp_sequenceId_i, ptp_messageType_i};
            end
          end else if (frame_end_i) begin
            m_open = 0;
          end else if (sfd_pulse_i && tsu_cfg_i[9]) begin
            m_sec = tx_ts_sec_i; m_ns = tx_ts_ns_i;
          end
        end else if (sfd_pulse_i && tsu_cfg_i[9]) begin
          m_open = 1; m_sec = tx_ts_sec_i; m_ns = tx_ts_ns_i;
        end
      end
      if (was_nonempty) m_last = q[0];
      if (pop_ok) void'(q.pop_front());
      if (do_push) begin
        if (full_before && !pop_ok) begin
          drop = 1;
`ifdef TX_TS_DROP_OLDEST_EN
          void'(q.pop_front());
          q.push_back(pe);
`endif
        end else begin
          q.push_back(pe);
        end
      end
      if (drop) m_ovf = 1;
      else if (ts_clr_ovf_i) m_ovf = 0;
      m_irq = tsu_cfg_i[8] && was_nonempty;
    end
  end

  always @(negedge tx_clk) begin
    if (chk_on) begin
      ent_t h;
      h = (q.size() != 0) ? q[0] : m_last;
      chk("valid", 64'(ts_valid_o), 64'(q.size() != 0));
      chk("count", 64'(ts_count_o), 64'(q.size()));
      chk("sec", 64'(ts_sec_o), 64'(h.sec));
      chk("ns", 64'(ts_ns_o), 64'(h.ns));
      chk("seqid", 64'(ts_seqid_o), 64'(h.seq));
      chk("msgtype", 64'(ts_msgtype_o), 64'(h.typ));
      chk("overflow", 64'(ts_overflow_o), 64'(m_ovf));
      chk("irq", 64'(ts_irq_o), 64'(m_irq));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge tx_clk);
    #2;
  endtask

  task automatic send_frame(input logic [47:0] s, input logic [31:0] n,
                            input logic [3:0] t, input logic [15:0] id, input bit pop_at_push);
    tx_ts_sec_i = s; tx_ts_ns_i = n; sfd_pulse_i = 1'b1;
    cyc();
    sfd_pulse_i = 1'b0; tx_ts_sec_i = 48'hABCD_EF01_2345; tx_ts_ns_i = 32'hDEAD_BEEF;
    cyc();
    is_ptp_message_i = 1'b1; ptp_messageType_i = t; ptp_sequenceId_i = id;
    cyc();
    is_ptp_message_i = 1'b0; ts_pop_i = pop_at_push;
    cyc();
    ts_pop_i = 1'b0; frame_end_i = 1'b1;
    cyc();
    frame_end_i = 1'b0;
  endtask

  task automatic pop1();
    ts_pop_i = 1'b1;
    cyc();
    ts_pop_i = 1'b0;
  endtask

  localparam logic [31:0] CFG_CAP = 32'h0000_0200;
  localparam logic [31:0] CFG_IRQ = 32'h0000_0100;
  localparam logic [31:0] CFG_1S  = 32'h0000_0001;

  initial begin
    int base;
    #1 tx_rst = 1'b1;
    cyc(); cyc();
    chk("rst_valid", 64'(ts_valid_o), 64'd0);
    chk("rst_count", 64'(ts_count_o), 64'd0);
    chk("rst_sec", 64'(ts_sec_o), 64'd0);
    chk("rst_ovf", 64'(ts_overflow_o), 64'd0);
    chk("rst_irq", 64'(ts_irq_o), 64'd0);
    tx_rst = 1'b0;
    chk_on = 1;
    cyc();

    // T1: basic two-step capture with latency and IRQ lag
    tsu_cfg_i = CFG_CAP | CFG_IRQ;
    tx_ts_sec_i = 48'd5; tx_ts_ns_i = 32'd1000; sfd_pulse_i = 1'b1;
    cyc();
    sfd_pulse_i = 1'b0; tx_ts_sec_i = 48'd77; tx_ts_ns_i = 32'd77;
    cyc();
    is_ptp_message_i = 1'b1; ptp_messageType_i = 4'd0; ptp_sequenceId_i = 16'h0010;
    cyc();
    is_ptp_message_i = 1'b0;
    chk("t1_lat_valid0", 64'(ts_valid_o), 64'd0);
    cyc();
    chk("t1_valid", 64'(ts_valid_o), 64'd1);
    chk("t1_sec", 64'(ts_sec_o), 64'd5);
    chk("t1_ns", 64'(ts_ns_o), 64'd1000);
    chk("t1_seq", 64'(ts_seqid_o), 64'h10);
    chk("t1_count", 64'(ts_count_o), 64'd1);
    chk("t1_irq_lag", 64'(ts_irq_o), 64'd0);
    cyc();
    chk("t1_irq", 64'(ts_irq_o), 64'd1);
    pop1();
    chk("t1_pop_valid", 64'(ts_valid_o), 64'd0);
    chk("t1_hold_sec", 64'(ts_sec_o), 64'd5);
    cyc();

    // T2: one-step mode qualifies only Delay_Req and Pdelay_Req
    tsu_cfg_i = CFG_CAP | CFG_1S;
    send_frame(48'd20, 32'd200, 4'd0, 16'h0020, 0);
    send_frame(48'd21, 32'd210, 4'd1, 16'h0021, 0);
    send_frame(48'd22, 32'd220, 4'd3, 16'h0022, 0);
    send_frame(48'd23, 32'd230, 4'd2, 16'h0023, 0);
    chk("t2_count", 64'(ts_count_o), 64'd2);
    chk("t2_head_seq", 64'(ts_seqid_o), 64'h21);
    chk("t2_head_type", 64'(ts_msgtype_o), 64'd1);
    pop1();
    chk("t2_next_seq", 64'(ts_seqid_o), 64'h23);
    chk("t2_next_ns", 64'(ts_ns_o), 64'd230);
    pop1();

    // T3: SFD + frame_end without PTP leaves no entry and no stale timestamp
    tsu_cfg_i = CFG_CAP;
    tx_ts_sec_i = 48'd7; tx_ts_ns_i = 32'd700; sfd_pulse_i = 1'b1;
    cyc();
    sfd_pulse_i = 1'b0; frame_end_i = 1'b1;
    cyc();
    frame_end_i = 1'b0;
    cyc(); cyc();
    chk("t3_nopush", 64'(ts_count_o), 64'd0);
    send_frame(48'd9, 32'd900, 4'd0, 16'h0030, 0);
    chk("t3_sec", 64'(ts_sec_o), 64'd9);
    chk("t3_ns", 64'(ts_ns_o), 64'd900);
    pop1();

    // T4: five frames into a depth-4 queue
    for (int i = 1; i <= 5; i++)
      send_frame(48'(100 + i), 32'(i), 4'd1, 16'(i), 0);
    chk("t4_count", 64'(ts_count_o), 64'd4);
    chk("t4_ovf", 64'(ts_overflow_o), 64'd1);
`ifdef TX_TS_DROP_OLDEST_EN
    base = 2;
`else
    base = 1;
`endif
    for (int i = 0; i < 4; i++) begin
      chk("t4_head", 64'(ts_seqid_o), 64'(base + i));
      pop1();
    end
    chk("t4_ovf_sticky", 64'(ts_overflow_o), 64'd1);
    ts_clr_ovf_i = 1'b1;
    cyc();
    ts_clr_ovf_i = 1'b0;
    chk("t4_ovf_clr", 64'(ts_overflow_o), 64'd0);

    // T5: push and pop together while full
    for (int i = 0; i < 4; i++)
      send_frame(48'(200 + i), 32'(i), 4'd0, 16'(16'h41 + i), 0);
    send_frame(48'd300, 32'd3, 4'd0, 16'h0045, 1);
    chk("t5_count", 64'(ts_count_o), 64'd4);
    chk("t5_head", 64'(ts_seqid_o), 64'h42);
    chk("t5_ovf", 64'(ts_overflow_o), 64'd0);
    for (int i = 0; i < 4; i++) pop1();

    // T6: gating, then reset during WAIT_CLS
    send_frame(48'd51, 32'd51, 4'd2, 16'h0051, 0);
    send_frame(48'd52, 32'd52, 4'd2, 16'h0052, 0);
    send_frame(48'd53, 32'd53, 4'd2, 16'h0053, 0);
    tx_clk_en_i = 1'b0;
    pop1();
    chk("t6_pop_gated", 64'(ts_count_o), 64'd2);
    sfd_pulse_i = 1'b1;
    cyc();
    sfd_pulse_i = 1'b0; tx_clk_en_i = 1'b1;
    is_ptp_message_i = 1'b1; ptp_messageType_i = 4'd0; ptp_sequenceId_i = 16'h0099;
    cyc();
    is_ptp_message_i = 1'b0;
    cyc(); cyc();
    chk("t6_gated_sfd", 64'(ts_count_o), 64'd2);
    tx_ts_sec_i = 48'd60; sfd_pulse_i = 1'b1;
    cyc();
    sfd_pulse_i = 1'b0;
    cyc();
    #1 tx_rst = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(ts_valid_o), 64'd0);
    chk("t6_rst_count", 64'(ts_count_o), 64'd0);
    chk("t6_rst_seq", 64'(ts_seqid_o), 64'd0);
    cyc();
    tx_rst = 1'b0;
    cyc();
    send_frame(48'd11, 32'd1100, 4'd1, 16'h0060, 0);
    chk("t6_after_count", 64'(ts_count_o), 64'd1);
    chk("t6_after_seq", 64'(ts_seqid_o), 64'h60);
    chk("t6_after_sec", 64'(ts_sec_o), 64'd11);
    cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tx_ts_queue_ctrl.md
Name: tx_ts_queue_ctrl

Overview:
- Sequences egress-timestamp capture for transmitted PTPv2 event messages.
- Takes the SFD-time timestamp from the TSU counter and tags it with the message's type and sequenceId once the TX parser classifies the frame.
- Queues qualifying entries in a small FIFO that the CPU drains through the register interface.
- Sits beside the TX embed/one-step path; it handles the two-step and Delay_Req cases that are not embedded on the wire.

Parameters:
- DEPTH, 4, number of FIFO entries (power of 2, 2..16).
- AW, 2, log2(DEPTH).

Ports:
- tx_clk  in  1  TX clock.
- tx_rst  in  1  Asynchronous, active-high reset.
- tx_clk_en_i  in  1  Datapath enable for GMII/MII adaptation.
- sfd_pulse_i  in  1  One-cycle pulse at SFD of every transmitted frame.
- tx_ts_sec_i  in  48  Seconds field of the timestamp sampled at SFD.
- tx_ts_ns_i  in  32  Nanoseconds field of the timestamp sampled at SFD.
- is_ptp_message_i  in  1  Parser classification strobe; a valid PTP header was found.
- ptp_messageType_i  in  4  messageType, valid with is_ptp_message_i.
- ptp_sequenceId_i  in  16  sequenceId, valid with is_ptp_message_i.
- frame_end_i  in  1  Pulse on the terminate character of the frame.
- tsu_cfg_i  in  32  Bit0 one_step; bit8 ts_irq_en; bit9 ts_capture_en.
- ts_pop_i  in  1  CPU pop pulse (register read side effect).
- ts_clr_ovf_i  in  1  Clears the sticky overflow flag.
- ts_valid_o  out  1  FIFO non-empty.
- ts_sec_o  out  48  Head-entry seconds.
- ts_ns_o  out  32  Head-entry nanoseconds.
- ts_seqid_o  out  16  Head-entry sequenceId.
- ts_msgtype_o  out  4  Head-entry messageType.
- ts_count_o  out  AW+1  Current occupancy.
- ts_overflow_o  out  1  Sticky: an entry was lost.
- ts_irq_o  out  1  Interrupt level.

Behaviour:
- Reset: every output is 0, FSM is IDLE, pointers are 0, and the latched timestamp is cleared.
- Gating: the FSM, timestamp latch and push logic advance only when tx_clk_en_i=1. ts_pop_i and ts_clr_ovf_i act on every tx_clk regardless of tx_clk_en_i.
- IDLE:
  - sfd_pulse_i & ts_capture_en: latch sec/ns, go to WAIT_CLS.
  - Otherwise stay in IDLE.
- WAIT_CLS:
  - is_ptp_message_i & qualified: go to PUSH, latching messageType and sequenceId.
  - is_ptp_message_i & not qualified: go to IDLE.
  - frame_end_i: go to IDLE (non-PTP frame, no push).
  - sfd_pulse_i: relatch the new timestamp and stay in WAIT_CLS (previous frame abandoned).
  - Priority: is_ptp_message_i over frame_end_i over sfd_pulse_i.
- PUSH: write one entry for one enabled cycle, then go to IDLE.
- Push latency: the entry is visible on ts_valid_o and ts_count_o 2 enabled cycles after the is_ptp_message_i strobe.
- Qualified:
  - ptp_messageType_i[3]=0 is required.
  - one_step=0: types 0, 1, 2 and 3 qualify.
  - one_step=1: only types 1 (Delay_Req) and 2 (Pdelay_Req) qualify.
- FIFO is first-word-fall-through: head fields are valid whenever ts_valid_o=1 and hold their last value when empty.
- Pop:
  - ts_pop_i with ts_valid_o=1 advances the read pointer; the next head is visible next cycle.
  - ts_pop_i when empty is ignored, with no state change.
- Simultaneous push and pop: both take effect and count is unchanged. This holds when full as well, so the push is accepted.
- Push while full without pop: the new entry is dropped, ts_overflow_o is set and count stays DEPTH.
- ts_overflow_o stays set until ts_clr_ovf_i. If a drop and a clear occur in the same cycle, set wins.
- ts_irq_o = ts_irq_en & ts_valid_o, registered (1-cycle lag).
- Pointers are AW bits and wrap modulo DEPTH. Count is AW+1 bits and saturates logically at DEPTH.
- Clearing ts_capture_en mid-frame: the FSM finishes the current frame normally; new SFDs are then ignored.

Optional Feature:
- Macro: TX_TS_DROP_OLDEST_EN.
- Defined: a push while full without pop overwrites the oldest entry.
  - The read pointer and write pointer both advance and count stays DEPTH.
  - ts_overflow_o is set.
  - The head moves to the second-oldest entry.
- Undefined: the newest entry is dropped, as described under Behaviour.

Decomposition:
- Shared ptpv2 package/defines holds:
  - messageType constants (SYNC=0, DELAY_REQ=1, PDELAY_REQ=2, PDELAY_RESP=3).
  - tsu_cfg bit indices (ONE_STEP=0, TS_IRQ_EN=8, TS_CAPTURE_EN=9).
  - Entry width constant: 100 bits = 48+32+16+4.
- Sub-module tx_ts_fifo: storage array, pointers, count, full/empty and drop-oldest logic.
- The top level holds the FSM, qualification logic and IRQ/overflow registers.

Test Plan:
- one_step=0, SFD with ts=(sec 5, ns 1000), then a type 0 message with seqId 0x0010 → 2 enabled cycles after the strobe: ts_valid_o=1, ts_sec_o=5, ts_ns_o=1000, ts_seqid_o=0x0010, ts_count_o=1; with ts_irq_en=1, ts_irq_o=1 one cycle later.
- one_step=1, send types 0, 1, 3, 2 → only the type 1 and type 2 entries are queued, in order; count=2.
- SFD followed by frame_end_i with no PTP strobe → no push; a subsequent PTP frame captures its own SFD timestamp, not the stale one.
- Send 5 qualifying frames with DEPTH=4 → without the macro: count=4, heads are seq 1–4, overflow=1; with the macro: heads are seq 2–5. ts_clr_ovf_i then clears overflow.
- Push and pop in the same cycle with count=4 → count stays 4, the head advances, no overflow.
- Assert tx_rst mid-WAIT_CLS with 2 entries queued → all outputs go to 0 immediately, and a later frame queues normally as the first entry.
